// File: rtl/bitlet_selector_pkg.sv
// Shared sizing constants and FSM state encoding for the bitlet selected-activation producer.
package bitlet_selector_pkg;

  localparam int BS_N_PAIR    = 64;
  localparam int BS_N_CHANNEL = 24;
  localparam int BS_WID_FIX   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/bitlet_ffs.sv
// Find-first-set over one channel's pending mask: lowest set index, found flag, one-hot clear.
module bitlet_ffs #(
  parameter int N_PAIR = 64,
  parameter int IDX_W  = $clog2(N_PAIR)
) (
  input  logic [N_PAIR-1:0] mask_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              found_o,
  output logic [N_PAIR-1:0] clr_o
);

  localparam logic [N_PAIR-1:0] ONE = {{(N_PAIR-1){1'b0}}, 1'b1};

  assign found_o = |mask_i;
  // Two's-complement trick isolates the lowest set bit.
  assign clr_o   = mask_i & (~mask_i + ONE);

  always_comb begin
    idx_o = '0;
    for (int i = N_PAIR - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = i[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/bitlet_selector.sv
// Decomposes weight magnitudes into per-bit channels and streams one selected activation
// per channel per cycle, closing each group with a single gap cycle.
module bitlet_selector
  import bitlet_selector_pkg::*;
#(
  parameter int N_PAIR    = BS_N_PAIR,
  parameter int N_CHANNEL = BS_N_CHANNEL,
  parameter int WID_FIX   = BS_WID_FIX
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_vld,
  output logic                          ld_rdy,
  input  logic [N_PAIR*WID_FIX-1:0]     ld_act,
  input  logic [N_PAIR*N_CHANNEL-1:0]   ld_mag,
  input  logic [N_PAIR-1:0]             ld_sgn,
  output logic                          Asel_vld,
  output logic [N_CHANNEL*WID_FIX-1:0]  Asel_vec,
  output logic                          grp_done,
  output logic                          busy
);

  localparam int IDX_W = $clog2(N_PAIR);

  state_e                    state_q, state_d;
  logic [N_PAIR-1:0]         mask_q [N_CHANNEL];
  logic [N_PAIR-1:0]         mask_d [N_CHANNEL];
  logic signed [WID_FIX-1:0] act_q  [N_PAIR];
  logic                      vld_q;
  logic [IDX_W-1:0]          ffs_idx [N_CHANNEL];
  logic [N_CHANNEL-1:0]      ffs_found;
  logic [N_PAIR-1:0]         ffs_clr [N_CHANNEL];
  logic                      load, running, rem_any;

  // Wrapping negate: the most negative value maps onto itself.
  function automatic logic signed [WID_FIX-1:0] sign_apply(
    input logic signed [WID_FIX-1:0] a,
    input logic                      neg
  );
    return neg ? -a : a;
  endfunction

  assign load    = (state_q == ST_IDLE) && ld_vld;
  assign running = (state_q == ST_RUN);
  assign ld_rdy  = (state_q == ST_IDLE);
  assign busy    = (state_q != ST_IDLE);
  assign Asel_vld = vld_q;
  assign grp_done = running && !rem_any;

  for (genvar c = 0; c < N_CHANNEL; c++) begin : g_ffs
    bitlet_ffs #(.N_PAIR(N_PAIR), .IDX_W(IDX_W)) u_ffs (
      .mask_i  (mask_q[c]),
      .idx_o   (ffs_idx[c]),
      .found_o (ffs_found[c]),
      .clr_o   (ffs_clr[c])
    );
  end

  // Mask transpose on load; per-channel lowest-bit retirement while running.
  always_comb begin
    rem_any = 1'b0;
    for (int c = 0; c < N_CHANNEL; c++) begin
      mask_d[c] = mask_q[c];
      if (load) begin
        for (int i = 0; i < N_PAIR; i++) mask_d[c][i] = ld_mag[i*N_CHANNEL + c];
      end else if (running) begin
        mask_d[c] = mask_q[c] & ~ffs_clr[c];
        rem_any   = rem_any | (|mask_d[c]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ld_vld) state_d = ST_RUN;
      ST_RUN:  if (!rem_any) state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Asel_vec = '0;
    for (int c = 0; c < N_CHANNEL; c++) begin
      if (running && ffs_found[c]) Asel_vec[c*WID_FIX +: WID_FIX] = act_q[ffs_idx[c]];
    end
  end

  // Stage p0: control state and pending masks (async reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vld_q   <= 1'b0;
      for (int c = 0; c < N_CHANNEL; c++) mask_q[c] <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= (state_d == ST_RUN);
      for (int c = 0; c < N_CHANNEL; c++) mask_q[c] <= mask_d[c];
    end
  end

  // Stage p0: sign-applied activation store; masks gate its visibility, so no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N_PAIR; i++)
        act_q[i] <= sign_apply(ld_act[i*WID_FIX +: WID_FIX], ld_sgn[i]);
    end
  end

endmodule

// File: tb/tb_bitlet_selector.sv
// Directed-vector bench for bitlet_selector with hand-computed expected lanes.
module tb_bitlet_selector;

  localparam int NP = 64;
  localparam int NC = 24;
  localparam int WF = 16;
  localparam int VW = NC * WF;

  logic            clk = 1'b0;
  logic            rst;
  logic            ld_vld;
  logic            ld_rdy;
  logic [NP*WF-1:0] ld_act;
  logic [NP*NC-1:0] ld_mag;
  logic [NP-1:0]   ld_sgn;
  logic            Asel_vld;
  logic [VW-1:0]   Asel_vec;
  logic            grp_done;
  logic            busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [VW-1:0] exp_vec;

  always #5 clk = ~clk;

  bitlet_selector dut (
    .clk      (clk),
    .rst      (rst),
    .ld_vld   (ld_vld),
    .ld_rdy   (ld_rdy),
    .ld_act   (ld_act),
    .ld_mag   (ld_mag),
    .ld_sgn   (ld_sgn),
    .Asel_vld (Asel_vld),
    .Asel_vec (Asel_vec),
    .grp_done (grp_done),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ld_act = '0;
    ld_mag = '0;
    ld_sgn = '0;
  endtask

  task automatic set_pair(input int i, input logic signed [WF-1:0] a,
                          input logic [NC-1:0] m, input logic s);
    ld_act[i*WF +: WF] = a;
    ld_mag[i*NC +: NC] = m;
    ld_sgn[i]          = s;
  endtask

  function automatic logic [VW-1:0] lane(input int c, input logic signed [WF-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    r[c*WF +: WF] = v;
    return r;
  endfunction

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (!ld_rdy && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, " rdy wait"}, {{(VW-1){1'b0}}, ld_rdy}, 1);
  endtask

  // Assert ld_vld for exactly the handshake edge; returns in the first RUN cycle.
  task automatic load_group(input string tag);
    wait_rdy(tag);
    ld_vld = 1'b1;
    step();
    ld_vld = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [VW-1:0] v, input logic gd);
    check_eq({tag, " vld"},  {{(VW-1){1'b0}}, Asel_vld}, 1);
    check_eq({tag, " vec"},  Asel_vec, v);
    check_eq({tag, " done"}, {{(VW-1){1'b0}}, grp_done}, {{(VW-1){1'b0}}, gd});
    check_eq({tag, " rdy"},  {{(VW-1){1'b0}}, ld_rdy}, 0);
  endtask

  task automatic check_gap(input string tag);
    check_eq({tag, " gap vld"},  {{(VW-1){1'b0}}, Asel_vld}, 0);
    check_eq({tag, " gap vec"},  Asel_vec, '0);
    check_eq({tag, " gap rdy"},  {{(VW-1){1'b0}}, ld_rdy}, 0);
    check_eq({tag, " gap busy"}, {{(VW-1){1'b0}}, busy}, 1);
    check_eq({tag, " gap done"}, {{(VW-1){1'b0}}, grp_done}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ld_vld = 1'b0;
    clear_inputs();
    step();
    step();
    check_eq("rst rdy",  {{(VW-1){1'b0}}, ld_rdy}, 1);
    check_eq("rst vld",  {{(VW-1){1'b0}}, Asel_vld}, 0);
    check_eq("rst vec",  Asel_vec, '0);
    check_eq("rst done", {{(VW-1){1'b0}}, grp_done}, 0);
    check_eq("rst busy", {{(VW-1){1'b0}}, busy}, 0);
    rst = 1'b0;
    step();

    // Single pair: act 5 with mag 0b101 lights lanes 0 and 2 once.
    clear_inputs();
    set_pair(0, 16'sd5, 24'h000005, 1'b0);
    load_group("single");
    check_run("single c1", lane(0, 16'sd5) | lane(2, 16'sd5), 1'b1);
    check_eq("single busy", {{(VW-1){1'b0}}, busy}, 1);
    step();
    check_gap("single");
    step();
    check_eq("single idle rdy", {{(VW-1){1'b0}}, ld_rdy}, 1);

    // Collision on channel 0 across three pairs; pair 1 negated.
    clear_inputs();
    set_pair(0, 16'sd3,  24'h000001, 1'b0);
    set_pair(1, -16'sd7, 24'h000001, 1'b1);
    set_pair(2, 16'sd2,  24'h000001, 1'b0);
    load_group("coll");
    check_run("coll c1", lane(0, 16'sd3), 1'b0);
    step();
    check_run("coll c2", lane(0, 16'sd7), 1'b0);
    step();
    check_run("coll c3", lane(0, 16'sd2), 1'b1);
    step();
    check_gap("coll");

    // All-zero magnitudes still produce one valid cycle.
    clear_inputs();
    set_pair(5, 16'sd99, 24'h000000, 1'b0);
    load_group("zero");
    check_run("zero c1", '0, 1'b1);
    step();
    check_gap("zero");
    step();
    check_eq("zero idle rdy", {{(VW-1){1'b0}}, ld_rdy}, 1);

    // Back-to-back with ld_vld held high; inputs change to group B during RUN.
    clear_inputs();
    set_pair(0, 16'sd10, 24'h000003, 1'b0);
    set_pair(1, 16'sd20, 24'h000001, 1'b0);
    wait_rdy("b2b");
    ld_vld = 1'b1;
    step();
    clear_inputs();
    set_pair(0, -16'sd4, 24'h000004, 1'b1);
    set_pair(3, 16'sd9,  24'h000008, 1'b0);
    check_run("b2b A1", lane(0, 16'sd10) | lane(1, 16'sd10), 1'b0);
    step();
    check_run("b2b A2", lane(0, 16'sd20), 1'b1);
    step();
    check_gap("b2b");
    step();
    check_eq("b2b load vld", {{(VW-1){1'b0}}, Asel_vld}, 0);
    check_eq("b2b load rdy", {{(VW-1){1'b0}}, ld_rdy}, 1);
    step();
    ld_vld = 1'b0;
    check_run("b2b B1", lane(2, 16'sd4) | lane(3, 16'sd9), 1'b1);
    step();
    check_gap("b2b B");

    // Negating the most negative activation wraps to itself.
    clear_inputs();
    set_pair(0, -16'sd32768, 24'h800000, 1'b1);
    load_group("neg");
    exp_vec = '0;
    exp_vec[23*WF +: WF] = 16'h8000;
    check_run("neg c1", exp_vec, 1'b1);
    step();
    check_gap("neg");

    // Reset in the second RUN cycle of a K=5 group.
    clear_inputs();
    for (int i = 0; i < 5; i++) set_pair(i, 16'(i + 1), 24'h000001, 1'b0);
    load_group("rstmid");
    check_run("rstmid c1", lane(0, 16'sd1), 1'b0);
    step();
    check_run("rstmid c2", lane(0, 16'sd2), 1'b0);
    rst = 1'b1;
    #1;
    check_eq("rstmid vld",  {{(VW-1){1'b0}}, Asel_vld}, 0);
    check_eq("rstmid rdy",  {{(VW-1){1'b0}}, ld_rdy}, 1);
    check_eq("rstmid done", {{(VW-1){1'b0}}, grp_done}, 0);
    check_eq("rstmid busy", {{(VW-1){1'b0}}, busy}, 0);
    check_eq("rstmid vec",  Asel_vec, '0);
    step();
    rst = 1'b0;
    step();
    check_eq("post rst idle vld", {{(VW-1){1'b0}}, Asel_vld}, 0);
    clear_inputs();
    set_pair(0, 16'sd11, 24'h000002, 1'b0);
    load_group("fresh");
    check_run("fresh c1", lane(1, 16'sd11), 1'b1);
    step();
    check_gap("fresh");
    step();
    check_eq("fresh idle rdy", {{(VW-1){1'b0}}, ld_rdy}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
